// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types for the round-robin memory arbiter: memory transaction payload,
// boolean alias and the arbiter FSM state encoding.
package mem_rr_arbiter_pkg;

  localparam int unsigned MEM_DW = 8;
  localparam int unsigned MEM_AW = 8;

  typedef logic bool;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] data;
    logic              wr;
  } mem_s;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping
// explicitly at N so non-power-of-2 requester counts work.
module mem_rr_arbiter_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = '0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      j = sum[IW-1:0];
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = j;
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory among N_REQ requesters,
// one transaction in flight, read data returned on a per-requester pulse.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_valid,
  input  mem_s              req_txn [N_REQ],
  output logic [N_REQ-1:0]  req_ready,
  output logic [N_REQ-1:0]  rsp_valid,
  output logic [MEM_DW-1:0] rsp_data,
  output logic              mem_en,
  output mem_s              mem_txn,
  input  logic [MEM_DW-1:0] mem_rdata,
  output bool               busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(RD_LATENCY + 1);

  arb_state_e        state, state_d;
  logic [N_REQ-1:0]  grant, grant_d;
  logic [IW-1:0]     gidx, gidx_d;
  logic [IW-1:0]     rr_ptr, rr_ptr_d;
  logic [CW-1:0]     cnt, cnt_d;
  mem_s              mem_txn_d;
  logic              mem_en_d;
  logic [N_REQ-1:0]  req_ready_d, rsp_valid_d;
  logic [MEM_DW-1:0] rsp_data_d;
  bool               busy_d;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  mem_rr_arbiter_rr_pick #(.N(N_REQ)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d     = state;
    grant_d     = grant;
    gidx_d      = gidx;
    rr_ptr_d    = rr_ptr;
    cnt_d       = cnt;
    mem_txn_d   = mem_txn;
    mem_en_d    = 1'b0;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_d     = pick_onehot;
          gidx_d      = pick_idx;
          mem_txn_d   = req_txn[pick_idx];
          mem_en_d    = 1'b1;
          req_ready_d = pick_onehot;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        rr_ptr_d = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
        if (mem_txn.wr) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CW'(RD_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          rsp_data_d  = mem_rdata;
          rsp_valid_d = grant;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      mem_txn   <= '0;
      mem_en    <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      grant     <= grant_d;
      gidx      <= gidx_d;
      rr_ptr    <= rr_ptr_d;
      cnt       <= cnt_d;
      mem_txn   <= mem_txn_d;
      mem_en    <= mem_en_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      busy      <= busy_d;
    end
  end

endmodule
